// File: rtl/sel_decoder_seq.sv
// Registered one-hot select generator with HOLD, timed STROBE and wrapping SCAN modes.
// A valid/ready request picks the mode; out-of-range or reserved requests pulse o_err.
module sel_decoder_seq #(
  parameter int ADDR_W    = 3,
  parameter int N_OUT     = 8,
  parameter int PULSE_LEN = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_clr,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_mode,
  output logic [N_OUT-1:0]  o_out,
  output logic [ADDR_W-1:0] o_idx,
  output logic              o_busy,
  output logic              o_err
);

  localparam int CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_SCAN   = 2'd3;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_STROBE = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_OUT - 1);
  localparam logic [N_OUT-1:0]  ONEHOT_LSB = {{(N_OUT-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(PULSE_LEN - 1);

  logic [1:0]        r_state;
  logic [N_OUT-1:0]  r_out;
  logic [ADDR_W-1:0] r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic              w_accept;
  logic              w_req_bad;
  logic [ADDR_W-1:0] w_idx_inc;
  logic [N_OUT-1:0]  w_onehot_req;
  logic [N_OUT-1:0]  w_onehot_idx;
  logic [N_OUT-1:0]  w_onehot_inc;

  assign o_req_ready  = i_enable & ~i_clr & (r_state != ST_STROBE);
  assign w_accept     = i_req_valid & o_req_ready;
  assign w_req_bad    = (32'(i_req_addr) >= N_OUT) | (i_req_mode == MODE_RSVD);
  assign w_idx_inc    = (r_idx == LAST_IDX) ? '0 : r_idx + ADDR_W'(1);
  assign w_onehot_req = ONEHOT_LSB << i_req_addr;
  assign w_onehot_idx = ONEHOT_LSB << r_idx;
  assign w_onehot_inc = ONEHOT_LSB << w_idx_inc;

  // In SCAN a zero output means we are resuming from a pause: redrive idx before advancing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (i_clr) begin
        r_state <= ST_IDLE;
        r_out   <= '0;
      end else if (!i_enable) begin
        r_out <= '0;
      end else if (w_accept) begin
        if (w_req_bad) begin
          r_state <= ST_IDLE;
          r_out   <= '0;
          r_err   <= 1'b1;
        end else begin
          r_idx <= i_req_addr;
          r_out <= w_onehot_req;
          r_cnt <= CNT_LOAD;
          case (i_req_mode)
            MODE_STROBE: r_state <= ST_STROBE;
            MODE_SCAN:   r_state <= ST_SCAN;
            MODE_HOLD:   r_state <= ST_HOLD;
            default:     r_state <= ST_HOLD;
          endcase
        end
      end else begin
        case (r_state)
          ST_HOLD: r_out <= w_onehot_idx;
          ST_STROBE: begin
            if (r_cnt == '0) begin
              r_state <= ST_IDLE;
              r_out   <= '0;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
              r_out <= w_onehot_idx;
            end
          end
          ST_SCAN: begin
            if (r_out == '0) begin
              r_out <= w_onehot_idx;
            end else begin
              r_idx <= w_idx_inc;
              r_out <= w_onehot_inc;
            end
          end
          default: r_out <= '0;
        endcase
      end
    end
  end

  assign o_out  = r_out;
  assign o_idx  = r_idx;
  assign o_busy = (r_state != ST_IDLE);
  assign o_err  = r_err;

endmodule
